// File: rtl/mmu_pkg.sv
// mmu_pkg: shared definitions for the systolic-array sequencer.
//   - command op encodings
//   - FSM state encoding (plain localparams, legacy-compatible)
//   - calc_lat(): pipeline latency through the array, ROWS + COLS
package mmu_pkg;

  localparam logic OP_LOAD_W  = 1'b0;
  localparam logic OP_COMPUTE = 1'b1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_W  = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Cycles for an activation to ripple through every row and column.
  function automatic int calc_lat(input int rows, input int cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/mmu_valid_pipe.sv
// mmu_valid_pipe: 1-bit delay line of DEPTH flops with asynchronous
// active-low clear. Used to track when array results leave the last column.
// Ports:
//   clk   clock
//   rstn  asynchronous active-low clear of every stage
//   din   bit entering the line
//   dout  din delayed by DEPTH cycles
module mmu_valid_pipe #(
  parameter int DEPTH = 15
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  generate
    if (DEPTH == 1) begin : g_single
      // Next state of a single-stage line is the input itself.
      always_comb sr_d = din;
    end else begin : g_multi
      // Shift towards the MSB; the MSB is the oldest entry.
      always_comb sr_d = {sr_q[DEPTH-2:0], din};
    end
  endgenerate

  // Delay-line storage, cleared asynchronously so no stale bit survives reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/mmu_ctrl.sv
// mmu_ctrl: command sequencer for a ROWS x COLS weight-stationary systolic
// array. One command at a time: LOAD_W reads ROWS weight rows (last row
// first) and shifts them into the array; COMPUTE streams cmd_len activation
// vectors through the array and writes results back.
// Optional build macro: MMU_CTRL_PERF_EN adds saturating perf counters
// perf_busy_cycles (cycles not IDLE) and perf_cmds (completed commands).
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only when IDLE)
//   cmd_op, cmd_base, cmd_len,
//   cmd_out_base                   command fields, latched on acceptance
//   w_rd_en/w_rd_addr              weight buffer read
//   arr_w_wen                      weight shift into array row 0
//   act_rd_en/act_rd_addr          activation buffer read
//   arr_en                         array compute enable
//   out_wr_en/out_wr_addr          output buffer write
//   done                           one-cycle completion pulse
//   busy                           state != IDLE
module mmu_ctrl
  import mmu_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [ADDR_WIDTH-1:0] cmd_out_base,
  output logic                  w_rd_en,
  output logic [ADDR_WIDTH-1:0] w_rd_addr,
  output logic                  arr_w_wen,
  output logic                  act_rd_en,
  output logic [ADDR_WIDTH-1:0] act_rd_addr,
  output logic                  arr_en,
  output logic                  out_wr_en,
  output logic [ADDR_WIDTH-1:0] out_wr_addr,
  output logic                  done,
  output logic                  busy
`ifdef MMU_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_busy_cycles,
  output logic [15:0]           perf_cmds
`endif
);

  localparam int LAT   = calc_lat(ROWS, COLS);
  localparam int LAT_W = $clog2(LAT + 1);
  localparam int CNT_W = (LEN_WIDTH > LAT_W) ? LEN_WIDTH : LAT_W;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ROWS_M1_ADR = ADDR_WIDTH'(ROWS - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  w_rd_en_q, w_rd_en_d;
  logic [ADDR_WIDTH-1:0] w_rd_addr_q, w_rd_addr_d;
  logic                  arr_w_wen_q, arr_w_wen_d;
  logic                  act_rd_en_q, act_rd_en_d;
  logic [ADDR_WIDTH-1:0] act_rd_addr_q, act_rd_addr_d;
  logic                  arr_en_q, arr_en_d;
  logic                  out_wr_en_q, out_wr_en_d;
  logic [ADDR_WIDTH-1:0] out_wr_addr_q, out_wr_addr_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  cmd_ready_q, cmd_ready_d;

  logic                  accept_s;
  logic [LEN_WIDTH-1:0]  len_m1_s;
  logic                  pipe_out_s;

  assign accept_s = cmd_valid && cmd_ready_q;
  assign len_m1_s = cmd_len - LEN_WIDTH'(1);

  // arr_en plus this LAT-1 deep line plus the out_wr_en flop puts each
  // write LAT+1 cycles after its activation read.
  mmu_valid_pipe #(
    .DEPTH (LAT - 1)
  ) u_out_pipe (
    .clk  (clk),
    .rstn (rstn),
    .din  (arr_en_q),
    .dout (pipe_out_s)
  );

  // Next-state, counter and strobe logic for the command FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    w_rd_en_d     = 1'b0;
    w_rd_addr_d   = w_rd_addr_q;
    act_rd_en_d   = 1'b0;
    act_rd_addr_d = act_rd_addr_q;
    // Write pointer advances after every write it has presented.
    if (out_wr_en_q) begin
      out_wr_addr_d = out_wr_addr_q + ADDR_ONE;
    end else begin
      out_wr_addr_d = out_wr_addr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          out_wr_addr_d = cmd_out_base;
          if (cmd_op == OP_LOAD_W) begin
            // Deepest row is read first so it shifts furthest into the array.
            state_d     = ST_LOAD_W;
            cnt_d       = CNT_W'(ROWS - 1);
            w_rd_en_d   = 1'b1;
            w_rd_addr_d = cmd_base + ROWS_M1_ADR;
          end else if (cmd_len != '0) begin
            state_d       = ST_COMPUTE;
            cnt_d         = CNT_W'(len_m1_s);
            act_rd_en_d   = 1'b1;
            act_rd_addr_d = cmd_base;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_W: begin
        if (cnt_q == '0) begin
          // One drain cycle covers the delayed arr_w_wen of the last row.
          state_d = ST_DRAIN;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d       = cnt_q - CNT_ONE;
          w_rd_en_d   = 1'b1;
          w_rd_addr_d = w_rd_addr_q - ADDR_ONE;
        end
      end
      ST_COMPUTE: begin
        if (cnt_q == '0) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(LAT);
        end else begin
          cnt_d         = cnt_q - CNT_ONE;
          act_rd_en_d   = 1'b1;
          act_rd_addr_d = act_rd_addr_q + ADDR_ONE;
        end
      end
      ST_DRAIN: begin
        // A drain count of N occupies exactly N cycles.
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    arr_w_wen_d = w_rd_en_q;
    arr_en_d    = act_rd_en_q;
    out_wr_en_d = pipe_out_s;
    done_d      = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      w_rd_en_q     <= 1'b0;
      w_rd_addr_q   <= '0;
      arr_w_wen_q   <= 1'b0;
      act_rd_en_q   <= 1'b0;
      act_rd_addr_q <= '0;
      arr_en_q      <= 1'b0;
      out_wr_en_q   <= 1'b0;
      out_wr_addr_q <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      cmd_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      w_rd_en_q     <= w_rd_en_d;
      w_rd_addr_q   <= w_rd_addr_d;
      arr_w_wen_q   <= arr_w_wen_d;
      act_rd_en_q   <= act_rd_en_d;
      act_rd_addr_q <= act_rd_addr_d;
      arr_en_q      <= arr_en_d;
      out_wr_en_q   <= out_wr_en_d;
      out_wr_addr_q <= out_wr_addr_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign w_rd_en     = w_rd_en_q;
  assign w_rd_addr   = w_rd_addr_q;
  assign arr_w_wen   = arr_w_wen_q;
  assign act_rd_en   = act_rd_en_q;
  assign act_rd_addr = act_rd_addr_q;
  assign arr_en      = arr_en_q;
  assign out_wr_en   = out_wr_en_q;
  assign out_wr_addr = out_wr_addr_q;
  assign done        = done_q;
  assign busy        = busy_q;

`ifdef MMU_CTRL_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [15:0] perf_cmds_q, perf_cmds_d;

  // Saturating increments; busy_q mirrors state != IDLE.
  always_comb begin
    if (busy_q && (perf_busy_q != 32'hFFFF_FFFF)) begin
      perf_busy_d = perf_busy_q + 32'd1;
    end else begin
      perf_busy_d = perf_busy_q;
    end
    if (done_q && (perf_cmds_q != 16'hFFFF)) begin
      perf_cmds_d = perf_cmds_q + 16'd1;
    end else begin
      perf_cmds_d = perf_cmds_q;
    end
  end

  // Perf counters are cleared only by rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_busy_q <= 32'd0;
      perf_cmds_q <= 16'd0;
    end else begin
      perf_busy_q <= perf_busy_d;
      perf_cmds_q <= perf_cmds_d;
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_cmds        = perf_cmds_q;
`endif

endmodule

// File: tb/tb_mmu_ctrl.sv
// tb_mmu_ctrl: directed self-checking bench for mmu_ctrl (ROWS=COLS=8,
// ADDR_WIDTH=LEN_WIDTH=10). Outputs are sampled on the falling edge; cycle
// k=1 is the first cycle after the accepting rising edge.
module tb_mmu_ctrl;

  logic       clk;
  logic       rstn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [9:0] cmd_base;
  logic [9:0] cmd_len;
  logic [9:0] cmd_out_base;
  logic       w_rd_en;
  logic [9:0] w_rd_addr;
  logic       arr_w_wen;
  logic       act_rd_en;
  logic [9:0] act_rd_addr;
  logic       arr_en;
  logic       out_wr_en;
  logic [9:0] out_wr_addr;
  logic       done;
  logic       busy;
`ifdef MMU_CTRL_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [15:0] perf_cmds;
`endif

  int checks;
  int errors;

  mmu_ctrl #(
    .ROWS(8), .COLS(8), .ADDR_WIDTH(10), .LEN_WIDTH(10)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_base     (cmd_base),
    .cmd_len      (cmd_len),
    .cmd_out_base (cmd_out_base),
    .w_rd_en      (w_rd_en),
    .w_rd_addr    (w_rd_addr),
    .arr_w_wen    (arr_w_wen),
    .act_rd_en    (act_rd_en),
    .act_rd_addr  (act_rd_addr),
    .arr_en       (arr_en),
    .out_wr_en    (out_wr_en),
    .out_wr_addr  (out_wr_addr),
    .done         (done),
    .busy         (busy)
`ifdef MMU_CTRL_PERF_EN
    ,
    .perf_busy_cycles (perf_busy_cycles),
    .perf_cmds        (perf_cmds)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a command for exactly one accepting edge.
  task automatic send_cmd(input logic op, input logic [9:0] base,
                          input logic [9:0] len, input logic [9:0] obase);
    @(negedge clk);
    cmd_op       = op;
    cmd_base     = base;
    cmd_len      = len;
    cmd_out_base = obase;
    cmd_valid    = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 4) rstn = 1'b1;
      checks++;
      if ({w_rd_en, arr_w_wen, act_rd_en, arr_en, out_wr_en, done} !== 6'b0) begin
        errors++;
        $display("FAIL reset_strobes k=%0d got %b exp 000000", k,
                 {w_rd_en, arr_w_wen, act_rd_en, arr_en, out_wr_en, done});
      end
      checks++;
      if ({cmd_ready, busy} !== 2'b10) begin
        errors++;
        $display("FAIL reset_ready_busy k=%0d got %b exp 10", k, {cmd_ready, busy});
      end
    end
  endtask

  task automatic test_load_w(input logic [9:0] base);
    logic       e_en, e_wen, e_done, e_ready;
    logic [9:0] e_addr;
    send_cmd(1'b0, base, 10'd0, 10'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      e_en    = (k >= 1) && (k <= 8);
      e_wen   = (k >= 2) && (k <= 9);
      e_done  = (k == 10);
      e_ready = (k >= 11);
      e_addr  = base + 10'(8 - k);
      checks++;
      if ({w_rd_en, arr_w_wen, done, cmd_ready, busy} !== {e_en, e_wen, e_done, e_ready, ~e_ready}) begin
        errors++;
        $display("FAIL load_ctrl k=%0d got %b exp %b", k, {w_rd_en, arr_w_wen, done, cmd_ready, busy},
                 {e_en, e_wen, e_done, e_ready, ~e_ready});
      end
      if (e_en) begin
        checks++;
        if (w_rd_addr !== e_addr) begin
          errors++;
          $display("FAIL load_addr k=%0d got %h exp %h", k, w_rd_addr, e_addr);
        end
      end
      checks++;
      if ({act_rd_en, arr_en, out_wr_en} !== 3'b0) begin
        errors++;
        $display("FAIL load_other_strobes k=%0d got %b exp 000", k, {act_rd_en, arr_en, out_wr_en});
      end
    end
  endtask

  task automatic test_compute(input logic [9:0] base, input int len, input logic [9:0] obase);
    logic       e_ar, e_ae, e_ow, e_done, e_ready;
    logic [9:0] e_ra, e_wa;
    send_cmd(1'b1, base, 10'(len), obase);
    for (int k = 1; k <= len + 19; k++) begin
      @(negedge clk);
      e_ar    = (k >= 1) && (k <= len);
      e_ae    = (k >= 2) && (k <= len + 1);
      e_ow    = (k >= 18) && (k <= len + 17);
      e_done  = (k == len + 17);
      e_ready = (k >= len + 18);
      e_ra    = base + 10'(k - 1);
      e_wa    = obase + 10'(k - 18);
      checks++;
      if ({act_rd_en, arr_en, out_wr_en, done, cmd_ready, busy, w_rd_en} !==
          {e_ar, e_ae, e_ow, e_done, e_ready, ~e_ready, 1'b0}) begin
        errors++;
        $display("FAIL compute_ctrl base=%h k=%0d got %b exp %b", base, k,
                 {act_rd_en, arr_en, out_wr_en, done, cmd_ready, busy, w_rd_en},
                 {e_ar, e_ae, e_ow, e_done, e_ready, ~e_ready, 1'b0});
      end
      if (e_ar) begin
        checks++;
        if (act_rd_addr !== e_ra) begin
          errors++;
          $display("FAIL compute_rd_addr k=%0d got %h exp %h", k, act_rd_addr, e_ra);
        end
      end
      if (e_ow) begin
        checks++;
        if (out_wr_addr !== e_wa) begin
          errors++;
          $display("FAIL compute_wr_addr k=%0d got %h exp %h", k, out_wr_addr, e_wa);
        end
      end
    end
  endtask

  task automatic test_len_zero();
    send_cmd(1'b1, 10'h050, 10'd0, 10'h200);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if ({w_rd_en, arr_w_wen, act_rd_en, arr_en, out_wr_en} !== 5'b0) begin
        errors++;
        $display("FAIL len0_strobes k=%0d got %b exp 00000", k,
                 {w_rd_en, arr_w_wen, act_rd_en, arr_en, out_wr_en});
      end
      checks++;
      if ({done, busy, cmd_ready} !== {(k == 1), (k == 1), (k >= 2)}) begin
        errors++;
        $display("FAIL len0_done k=%0d got %b exp %b", k, {done, busy, cmd_ready},
                 {(k == 1), (k == 1), (k >= 2)});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       e_en, e_done, e_ready;
    logic [9:0] e_addr;
    @(negedge clk);
    cmd_op = 1'b0; cmd_base = 10'h040; cmd_len = 10'd3; cmd_out_base = 10'd0;
    cmd_valid = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      e_en    = ((k >= 1) && (k <= 8)) || ((k >= 12) && (k <= 19));
      e_done  = (k == 10) || (k == 21);
      e_ready = (k == 11) || (k >= 22);
      e_addr  = (k < 12) ? 10'(10'h047 - 10'(k - 1)) : 10'(10'h047 - 10'(k - 12));
      checks++;
      if ({w_rd_en, done, cmd_ready} !== {e_en, e_done, e_ready}) begin
        errors++;
        $display("FAIL b2b_ctrl k=%0d got %b exp %b", k, {w_rd_en, done, cmd_ready},
                 {e_en, e_done, e_ready});
      end
      if (e_en) begin
        checks++;
        if (w_rd_addr !== e_addr) begin
          errors++;
          $display("FAIL b2b_addr k=%0d got %h exp %h", k, w_rd_addr, e_addr);
        end
      end
      if (k == 12) cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    send_cmd(1'b1, 10'h020, 10'd5, 10'h100);
    repeat (3) @(negedge clk);
    checks++;
    if ({act_rd_en, act_rd_addr} !== {1'b1, 10'h022}) begin
      errors++;
      $display("FAIL midrst_pre got %b/%h exp 1/022", act_rd_en, act_rd_addr);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({act_rd_en, arr_en, out_wr_en, done, busy, cmd_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL midrst_async got %b exp 000001",
               {act_rd_en, arr_en, out_wr_en, done, busy, cmd_ready});
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      checks++;
      if ({act_rd_en, arr_en, out_wr_en, done, cmd_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL midrst_after k=%0d got %b exp 00001", k,
                 {act_rd_en, arr_en, out_wr_en, done, cmd_ready});
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 1'b0;
    cmd_base = 10'd0;
    cmd_len = 10'd0;
    cmd_out_base = 10'd0;
    test_reset();
    test_load_w(10'h010);
    test_compute(10'h020, 5, 10'h100);
    test_len_zero();
    test_compute(10'h3FE, 4, 10'h3FF);
    test_back_to_back();
    test_reset_mid();
    test_load_w(10'h3FC);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
